// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and word-memory signals of the data memory access unit
interface mem_access_unit_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store unit in front of a word-only data memory
module mem_access_unit #(
    parameter int ADDR_W = 14
) (
    input  logic            clock,
    input  logic            rst_n,
    mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      state;
    logic        wr_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merged;

    // Byte address bits above the memory window wrap around by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = |bus.req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        byte_sel  = bus.mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel  = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        load_data = bus.mem_rdata;
        case (size_q)
            2'b00:   load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_data = bus.mem_rdata;
        endcase
    end

    // Read-modify-write: replace only the addressed lane of the captured word.
    always_comb begin
        merged = bus.mem_rdata;
        case (size_q)
            2'b00: merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (lane_q[1]) merged[31:16] = wdata_q;
                else           merged[15:0]  = wdata_q;
            end
            default: merged = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wr_q           <= 1'b0;
            uns_q          <= 1'b0;
            size_q         <= 2'b00;
            lane_q         <= 2'b00;
            wdata_q        <= 16'h0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.mem_addr   <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_wdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wr_q          <= bus.req_write;
                        uns_q         <= bus.req_unsigned;
                        size_q        <= bus.req_size;
                        lane_q        <= bus.req_addr[1:0];
                        wdata_q       <= bus.req_wdata[15:0];
                        bus.req_ready <= 1'b0;
                        if (misaligned) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= 32'h0;
                            state          <= RESP;
                        end else if (bus.req_write && bus.req_size == 2'b10) begin
                            bus.mem_addr  <= bus.req_addr[ADDR_W+1:2];
                            bus.mem_we    <= 1'b1;
                            bus.mem_wdata <= bus.req_wdata;
                            state         <= WR;
                        end else begin
                            bus.mem_addr <= bus.req_addr[ADDR_W+1:2];
                            state        <= RD;
                        end
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    if (wr_q) begin
                        bus.mem_wdata <= merged;
                        bus.mem_we    <= 1'b1;
                        state         <= WR;
                    end else begin
                        bus.resp_rdata <= load_data;
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                    end
                end
                WR: begin
                    bus.mem_we     <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= 32'h0;
                    state          <= RESP;
                end
                RESP: begin
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= 32'h0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    bus.mem_we    <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with a synchronous word memory model
module tb_mem_access_unit;
    localparam int ADDR_W = 14;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [31:0]       pre_data = 32'h0;

    // Synchronous-read memory: data for the address of cycle C appears in cycle C+1.
    always @(posedge clock) begin
        if (pre_we)          mem[pre_addr]     <= pre_data;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clock);
        pre_we   = 1'b0;
    endtask

    int          resp_at, we_at, we_n;
    logic [31:0] we_data, we_addr, rdata;
    logic        err;

    // Issue one request from a negedge with the unit idle; offsets are cycles after acceptance.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] d);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        resp_at = -1; we_at = -1; we_n = 0;
        we_data = 32'h0; we_addr = 32'h0; rdata = 32'h0; err = 1'b0;
        @(negedge clock);
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 8 && resp_at < 0; k++) begin
            if (k > 1) @(negedge clock);
            if (bus.mem_we) begin
                we_n++;
                we_at   = k;
                we_data = bus.mem_wdata;
                we_addr = 32'(bus.mem_addr);
            end
            if (bus.resp_valid) begin
                resp_at = k;
                rdata   = bus.resp_rdata;
                err     = bus.resp_err;
            end
        end
        @(negedge clock);
    endtask

    task automatic load_check(input string tag, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, input logic [31:0] exp);
        run_req(1'b0, sz, u, a, 32'h0);
        check({tag, "_lat"}, 32'(resp_at), 32'd3);
        check({tag, "_data"}, rdata, exp);
    endtask

    task automatic err_check(input string tag, input logic w, input logic [1:0] sz, input logic [31:0] a);
        run_req(w, sz, 1'b0, a, 32'h1234_5678);
        check({tag, "_lat"}, 32'(resp_at), 32'd1);
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_we"}, 32'(we_n), 32'd0);
        check({tag, "_rdata"}, rdata, 32'h0);
    endtask

    int   acc, pulses, seen;
    logic prev_we;

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clock);

        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check("wst_we_at", 32'(we_at), 32'd1);
        check("wst_we_n", 32'(we_n), 32'd1);
        check("wst_addr", we_addr, 32'd4);
        check("wst_wdata", we_data, 32'hDEAD_BEEF);
        check("wst_resp_at", 32'(resp_at), 32'd2);
        check("wst_rdata", rdata, 32'h0);
        load_check("wld", 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);

        preload(14'd4, 32'h1122_3344);
        run_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h5555_55AA);
        check("bst_we_at", 32'(we_at), 32'd3);
        check("bst_we_n", 32'(we_n), 32'd1);
        check("bst_wdata", we_data, 32'h11AA_3344);
        check("bst_resp_at", 32'(resp_at), 32'd4);
        check("bst_mem", mem[4], 32'h11AA_3344);
        run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_BEEF);
        check("hst_wdata", we_data, 32'hBEEF_3344);
        check("hst_resp_at", 32'(resp_at), 32'd4);

        preload(14'd8, 32'h8000_F0FF);
        load_check("lb_s0", 2'b00, 1'b0, 32'h20, 32'hFFFF_FFFF);
        load_check("lb_u0", 2'b00, 1'b1, 32'h20, 32'h0000_00FF);
        load_check("lb_s1", 2'b00, 1'b0, 32'h21, 32'hFFFF_FFF0);
        load_check("lb_s2", 2'b00, 1'b0, 32'h22, 32'h0000_0000);
        load_check("lh_s2", 2'b01, 1'b0, 32'h22, 32'hFFFF_8000);
        load_check("lh_u2", 2'b01, 1'b1, 32'h22, 32'h0000_8000);
        load_check("lh_s0", 2'b01, 1'b0, 32'h20, 32'hFFFF_F0FF);
        load_check("lw_u", 2'b10, 1'b1, 32'h20, 32'h8000_F0FF);

        err_check("mis_half", 1'b0, 2'b01, 32'h13);
        err_check("mis_word", 1'b1, 2'b10, 32'h12);
        err_check("mis_size", 1'b1, 2'b11, 32'h10);

        run_req(1'b1, 2'b10, 1'b0, 32'h0001_0010, 32'h0BAD_CAFE);
        check("wrap_addr", we_addr, 32'd4);
        check("wrap_mem", mem[4], 32'h0BAD_CAFE);

        bus.req_write = 1'b1; bus.req_size = 2'b10; bus.req_valid = 1'b1;
        acc = 0; pulses = 0; prev_we = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k % 3 == 0) begin
                bus.req_addr  = 32'h40 + 32'(4 * (k / 3));
                bus.req_wdata = 32'hA000_0000 + 32'(k);
            end
            if (bus.req_valid && bus.req_ready) acc++;
            if (bus.mem_we && !prev_we) pulses++;
            prev_we = bus.mem_we;
            check("b2b_ready", 32'(bus.req_ready), 32'(k % 3 == 0));
            check("b2b_we", 32'(bus.mem_we), 32'(k % 3 == 1));
            if (k == 8) bus.req_valid = 1'b0;
            @(negedge clock);
        end
        check("b2b_accepts", 32'(acc), 32'd3);
        check("b2b_pulses", 32'(pulses), 32'd3);
        check("b2b_mem0", mem[16], 32'hA000_0000);
        check("b2b_mem1", mem[17], 32'hA000_0003);
        check("b2b_mem2", mem[18], 32'hA000_0006);

        // Abandon a load and then a byte store while in CAP.
        for (int t = 0; t < 2; t++) begin
            preload(14'h21, 32'hCAFE_F00D);
            bus.req_valid = 1'b1; bus.req_write = (t == 1); bus.req_size = 2'b00;
            bus.req_addr = 32'h85; bus.req_wdata = 32'h77;
            @(negedge clock);
            bus.req_valid = 1'b0;
            @(negedge clock);
            rst_n = 1'b0;
            #1;
            check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
            check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
            check("mid_rst_mem_addr", 32'(bus.mem_addr), 32'h0);
            check("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
            @(negedge clock);
            rst_n = 1'b1;
            seen = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clock);
                if (bus.resp_valid || bus.mem_we) seen++;
            end
            check("mid_rst_quiet", 32'(seen), 32'd0);
            check("mid_rst_mem", mem[14'h21], 32'hCAFE_F00D);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
